// File: rtl/bus_arbiter_mux_if.sv
// Bus-side bundle of the arbitrating bus multiplexer.
//   master : the environment side. It drives mode/select/req/lock/mux_input
//            and observes gnt/bus_out/bus_src/bus_valid.
//   slave  : the bus_arbiter_mux side.
// The WIDTH and N parameters must match the ones given to bus_arbiter_mux.
interface bus_arbiter_mux_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8
);
    localparam int SELW = $clog2(N);

    logic             mode;
    logic [SELW-1:0]  select;
    logic [N-1:0]     req;
    logic             lock;
    logic [WIDTH-1:0] mux_input [0:N-1];
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] bus_out;
    logic [SELW-1:0]  bus_src;
    logic             bus_valid;

    modport master (
        output mode, select, req, lock, mux_input,
        input  gnt, bus_out, bus_src, bus_valid
    );

    modport slave (
        input  mode, select, req, lock, mux_input,
        output gnt, bus_out, bus_src, bus_valid
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered N-source common-bus multiplexer with round-robin arbitration.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of bus_arbiter_mux_if
//     mode=0 : direct select. The source is taken from select.
//     mode=1 : arbitration. Requesters in req compete for the bus. Tenure is
//              bounded by MAX_HOLD, and lock pins the current owner.
//     gnt / bus_out / bus_src / bus_valid are all registered.
module bus_arbiter_mux #(
    parameter int WIDTH    = 16,
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_arbiter_mux_if.slave    bus
);
    localparam int SELW = $clog2(N);
    localparam int CNTW = $clog2(MAX_HOLD + 1);
    localparam logic [CNTW-1:0] HOLD_MAX = CNTW'(MAX_HOLD);

    typedef enum logic {IDLE, OWNED} state_e;

    state_e           state_q, state_d;
    logic [SELW-1:0]  owner_q, owner_d;
    logic [SELW-1:0]  last_q, last_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic [SELW-1:0]  bus_src_q, bus_src_d;
    logic             bus_valid_q, bus_valid_d;

    // Round-robin pick. Scan last+1 .. last+N (mod N). The final slot is
    // last itself, so the current owner can win again only if it is the
    // sole requester.
    logic             rr_found;
    logic [SELW-1:0]  rr_win;
    int               rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = last_q;
        rr_idx   = 0;
        for (int i = 1; i <= N; i++) begin
            rr_idx = (int'(last_q) + i) % N;
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = SELW'(rr_idx);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!bus.mode) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        state_d = OWNED;
                        owner_d = rr_win;
                        last_d  = rr_win;
                        cnt_d   = CNTW'(1);
                    end
                end
                OWNED: begin
                    if (bus.lock) begin
                        if (cnt_q != HOLD_MAX) cnt_d = cnt_q + CNTW'(1);
                    end else if (!bus.req[owner_q]) begin
                        // Owner released: hand over in the same cycle (no bubble).
                        if (rr_found) begin
                            owner_d = rr_win;
                            last_d  = rr_win;
                            cnt_d   = CNTW'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q != HOLD_MAX) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end else if (rr_found && rr_win != owner_q) begin
                        // Tenure expired and someone else is waiting.
                        owner_d = rr_win;
                        last_d  = rr_win;
                        cnt_d   = CNTW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values, registered from the next state.
    logic [SELW-1:0]  sel_idx;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_data;

    always_comb begin
        if (!bus.mode) begin
            sel_idx = bus.select;
            sel_ok  = int'(bus.select) < N;
        end else begin
            sel_idx = owner_d;
            sel_ok  = (state_d == OWNED);
        end
        // Compare loop instead of direct indexing, so a select >= N never
        // addresses past the end of the source array.
        sel_data = '0;
        for (int i = 0; i < N; i++)
            if (sel_idx == SELW'(i)) sel_data = bus.mux_input[i];

        gnt_d       = sel_ok ? (N'(1) << sel_idx) : '0;
        bus_out_d   = sel_ok ? sel_data : '0;
        bus_valid_d = sel_ok;
        // Direct mode always reports select. Arbitration IDLE keeps the old source.
        bus_src_d   = (!bus.mode || sel_ok) ? sel_idx : bus_src_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= SELW'(N - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            bus_out_q   <= '0;
            bus_src_q   <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            bus_out_q   <= bus_out_d;
            bus_src_q   <= bus_src_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.bus_out   = bus_out_q;
    assign bus.bus_src   = bus_src_q;
    assign bus.bus_valid = bus_valid_q;
endmodule
